rl_modexp_ctrl: RTL and testbench

//  Sequencer for right-to-left binary modular exponentiation: result = base^exp mod modulus.

---
 rtl/rl_modexp_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rl_modexp_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_modexp_ctrl.sv
// Right-to-left binary modular exponentiation sequencer.
// Drives a shared LD (domain conversion) unit and a shared Montgomery multiplier.
module rl_modexp_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned EBITS = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [EBITS-1:0] exp,
   input  logic [WIDTH-1:0] modulus,
   input  logic [7:0]       len,
   output logic             ld_start,
   output logic [WIDTH-1:0] ld_num,
   input  logic             ld_end,
   input  logic [WIDTH-1:0] ld_out,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   input  logic             mm_end,
   input  logic [WIDTH-1:0] mm_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [2:0] {
      StIdle, StConvB, StConv1, StTest, StMul, StSqr, StOut, StDone
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, acc_q, acc_d;
   logic [EBITS-1:0] e_sh_q, e_sh_d;
   logic [WIDTH-1:0] modulus_q, modulus_d;
   logic [7:0]       len_q, len_d;
   logic             ld_start_q, ld_start_d, mm_start_q, mm_start_d;
   logic [WIDTH-1:0] ld_num_q, ld_num_d, mm_a_q, mm_a_d, mm_b_q, mm_b_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             mod_bad;

   // Latched for the host view only; the units take modulus/len straight from the host.
   logic unused_latched;
   assign unused_latched = ^{modulus_q, len_q};

   assign mod_bad = ~modulus[0] | (modulus < WIDTH'(3));

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      acc_d      = acc_q;
      e_sh_d     = e_sh_q;
      modulus_d  = modulus_q;
      len_d      = len_q;
      ld_start_d = 1'b0;
      mm_start_d = 1'b0;
      ld_num_d   = ld_num_q;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      result_d   = result_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               modulus_d = modulus;
               len_d     = len;
               e_sh_d    = exp;
               err_d     = 1'b0;
               result_d  = '0;
               if (mod_bad) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  busy_d     = 1'b1;
                  ld_start_d = 1'b1;
                  ld_num_d   = base;
                  state_d    = StConvB;
               end
            end
         end
         StConvB: begin
            if (ld_end) begin
               x_d        = ld_out;
               ld_start_d = 1'b1;
               ld_num_d   = WIDTH'(1);
               state_d    = StConv1;
            end
         end
         StConv1: begin
            if (ld_end) begin
               acc_d = ld_out;
               if (e_sh_q == '0) begin
                  mm_start_d = 1'b1;
                  mm_a_d     = ld_out;
                  mm_b_d     = WIDTH'(1);
                  state_d    = StOut;
               end else begin
                  state_d = StTest;
               end
            end
         end
         StTest: begin
            mm_start_d = 1'b1;
            if (e_sh_q[0]) begin
               mm_a_d  = acc_q;
               mm_b_d  = x_q;
               state_d = StMul;
            end else begin
               mm_a_d  = x_q;
               mm_b_d  = x_q;
               state_d = StSqr;
            end
         end
         StMul: begin
            if (mm_end) begin
               acc_d      = mm_out;
               mm_start_d = 1'b1;
               // Last set bit consumed: skip the trailing square.
               if ((e_sh_q >> 1) == '0) begin
                  mm_a_d  = mm_out;
                  mm_b_d  = WIDTH'(1);
                  state_d = StOut;
               end else begin
                  mm_a_d  = x_q;
                  mm_b_d  = x_q;
                  state_d = StSqr;
               end
            end
         end
         StSqr: begin
            if (mm_end) begin
               x_d     = mm_out;
               e_sh_d  = e_sh_q >> 1;
               state_d = StTest;
            end
         end
         StOut: begin
            if (mm_end) begin
               result_d = mm_out;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         x_q        <= '0;
         acc_q      <= '0;
         e_sh_q     <= '0;
         modulus_q  <= '0;
         len_q      <= '0;
         ld_start_q <= 1'b0;
         mm_start_q <= 1'b0;
         ld_num_q   <= '0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         e_sh_q     <= e_sh_d;
         modulus_q  <= modulus_d;
         len_q      <= len_d;
         ld_start_q <= ld_start_d;
         mm_start_q <= mm_start_d;
         ld_num_q   <= ld_num_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         result_q   <= result_d;
      end
   end

   assign ld_start = ld_start_q;
   assign ld_num   = ld_num_q;
   assign mm_start = mm_start_q;
   assign mm_a     = mm_a_q;
   assign mm_b     = mm_b_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign result   = result_q;

endmodule

// File: tb/tb_rl_modexp_ctrl.sv
// Bench for rl_modexp_ctrl: behavioural LD/MM units, plain modexp reference, scoreboard.
module tb_rl_modexp_ctrl;
   localparam int W = 32;
   localparam int E = 32;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic         start;
   logic [W-1:0] base, modulus;
   logic [E-1:0] exp;
   logic [7:0]   len;
   logic         ld_start, ld_end, mm_start, mm_end;
   logic [W-1:0] ld_num, ld_out, mm_a, mm_b, mm_out;
   logic         busy, done, err;
   logic [W-1:0] result;

   rl_modexp_ctrl #(.WIDTH(W), .EBITS(E)) dut (
      .clk(clk), .rstn(rstn), .start(start), .base(base), .exp(exp),
      .modulus(modulus), .len(len),
      .ld_start(ld_start), .ld_num(ld_num), .ld_end(ld_end), .ld_out(ld_out),
      .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_end(mm_end), .mm_out(mm_out),
      .busy(busy), .done(done), .err(err), .result(result)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           n_ld;
      int           n_mm;
   } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;
   int ld_cnt = 0, mm_cnt = 0, done_cnt = 0;
   int ld0, mm0;
   bit auto_mm = 1'b1;
   bit inject_mm = 1'b0;
   longint unsigned m_mod = 64'd3;
   int unsigned     m_len = 2;

   always @(posedge clk) begin
      if (ld_start) ld_cnt <= ld_cnt + 1;
      if (mm_start) mm_cnt <= mm_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
   end

   function automatic logic [W-1:0] ld_model(input logic [W-1:0] num);
      longint unsigned t;
      t = {32'b0, num};
      return W'((t << m_len) % m_mod);
   endfunction

   function automatic logic [W-1:0] mm_model(input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned t = 0;
      for (int i = 0; i < int'(m_len); i++) begin
         if (a[i]) t += {32'b0, b};
         if (t[0]) t += m_mod;
         t = t >> 1;
      end
      if (t >= m_mod) t -= m_mod;
      return W'(t);
   endfunction

   initial begin : ld_unit
      ld_end = 1'b0;
      ld_out = '0;
      forever begin
         @(negedge clk);
         ld_end = 1'b0;
         if (ld_start) begin
            repeat (2) @(negedge clk);
            ld_out = ld_model(ld_num);
            ld_end = 1'b1;
         end
      end
   end

   initial begin : mm_unit
      mm_end = 1'b0;
      mm_out = '0;
      forever begin
         @(negedge clk);
         mm_end = 1'b0;
         if (inject_mm) begin
            mm_out    = 32'h1234_5678;
            mm_end    = 1'b1;
            inject_mm = 1'b0;
         end else if (mm_start && auto_mm) begin
            repeat (3) @(negedge clk);
            mm_out = mm_model(mm_a, mm_b);
            mm_end = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic exp_t reference(input logic [W-1:0] b, input logic [E-1:0] e,
                                      input logic [W-1:0] m);
      exp_t r;
      longint unsigned acc, x, mm;
      int msb;
      if (!m[0] || m < 3) begin
         r.res = '0; r.err = 1'b1; r.n_ld = 0; r.n_mm = 0;
         return r;
      end
      mm  = {32'b0, m};
      acc = 1;
      x   = {32'b0, b} % mm;
      msb = 0;
      for (int i = 0; i < E; i++) begin
         if (e[i]) begin
            acc = (acc * x) % mm;
            msb = i;
         end
         x = (x * x) % mm;
      end
      r.res  = W'(acc);
      r.err  = 1'b0;
      r.n_ld = 2;
      r.n_mm = (e == '0) ? 1 : $countones(e) + msb + 1;
      return r;
   endfunction

   task automatic issue(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m,
                        input logic [7:0] l, input bit push);
      base    = b;
      exp     = e;
      modulus = m;
      len     = l;
      m_mod   = {32'b0, m};
      m_len   = {24'b0, l};
      if (push) sb.push_back(reference(b, e, m));
      ld0   = ld_cnt;
      mm0   = mm_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_op(input string tag, input int max_cyc);
      exp_t x;
      bit   got = 1'b0;
      int   gaps = 0;
      for (int i = 0; i < max_cyc; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (!busy) gaps++;
         @(negedge clk);
      end
      x = sb.pop_front();
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      check({tag, "_result"}, 64'(result), 64'(x.res));
      check({tag, "_err"}, 64'(err), 64'(x.err));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_ld_starts"}, 64'(ld_cnt - ld0), 64'(x.n_ld));
      check({tag, "_mm_starts"}, 64'(mm_cnt - mm0), 64'(x.n_mm));
      if (!x.err) check({tag, "_busy_gaps"}, 64'(gaps), 64'd0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
   endtask

   initial begin : main
      int d0;
      bit seen;
      start = 1'b0; base = '0; exp = '0; modulus = '0; len = '0;
      #3 rstn = 1'b0;
      #1;
      check("rst_outputs", 64'({ld_start, mm_start, busy, done, err}), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_operands", 64'(ld_num | mm_a | mm_b), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      issue(32'd4, 32'd13, 32'd497, 8'd9, 1'b1);
      finish_op("e13", 500);

      issue(32'd5, 32'd0, 32'd13, 8'd4, 1'b1);
      finish_op("e0", 500);

      // Starts while busy must be ignored.
      issue(32'd2, 32'd10, 32'd1001, 8'd10, 1'b1);
      repeat (4) @(negedge clk);
      base = 32'd7; exp = 32'd3; modulus = 32'd99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      modulus = 32'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_op("busy_ign", 500);

      issue(32'd3, 32'd5, 32'd10, 8'd4, 1'b1);
      finish_op("even_mod", 3);

      issue(32'd0, 32'd7, 32'd1, 8'd2, 1'b1);
      finish_op("mod_one", 3);

      // Reset while waiting on the multiplier, then a late mm_end.
      auto_mm = 1'b0;
      issue(32'd4, 32'd13, 32'd497, 8'd9, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (mm_start) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("abort_mm_start_seen", 64'(seen), 64'd1);
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("abort_outputs", 64'({ld_start, mm_start, busy, done, err}), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      d0 = done_cnt;
      inject_mm = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_idle", 64'({busy, ld_start, mm_start}), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      auto_mm = 1'b1;
      issue(32'd4, 32'd13, 32'd497, 8'd9, 1'b1);
      finish_op("after_abort", 500);

      // Stray mm_end while converting the base.
      issue(32'd4, 32'd13, 32'd497, 8'd9, 1'b1);
      inject_mm = 1'b1;
      finish_op("spurious_mm", 500);

      issue(32'h0123_4567, 32'hF00D_1235, 32'h7FFF_FFED, 8'd31, 1'b1);
      finish_op("wide", 3000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
